// File: rtl/ped_crossing_ctrl_pkg.sv
// Pedestrian crossing controller: state encoding and default timing.
// Shared by the top FSM and its button front end.
package ped_crossing_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RED = 3'd1,
        ST_WALK     = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_HOLD     = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    localparam int WALK_CYC_DEF  = 20;
    localparam int CLEAR_CYC_DEF = 10;
    localparam int FLASH_DIV_DEF = 2;
    localparam int CNT_W_DEF     = 8;
    localparam int CHIRP_DIV     = 4;

endpackage

// File: rtl/ped_crossing_ctrl_btn_sync.sv
// Push-button front end: two-flop synchroniser and a one-cycle
// registered pulse on each synchronised rising edge.
module ped_crossing_ctrl_btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            press <= s1 & ~s2;
        end
    end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian signal stage: WALK / flashing DON'T-WALK after vehicle red.
// Optional audio chirp is built only when PED_AUDIO_EN is defined.
module ped_crossing_ctrl
    import ped_crossing_ctrl_pkg::*;
#(
    parameter int WALK_CYC  = WALK_CYC_DEF,
    parameter int CLEAR_CYC = CLEAR_CYC_DEF,
    parameter int FLASH_DIV = FLASH_DIV_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             req_pend,
    output logic [CNT_W-1:0] countdown,
    output logic             fault,
    output logic             chirp
);

    state_t           state;
    logic             press;
    logic             red_q;
    logic             red_rise;
    logic             onehot;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] flash_cnt;

    ped_crossing_ctrl_btn_sync u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (ped_btn),
        .press (press)
    );

    assign red_rise = red & ~red_q;
    assign onehot   = $onehot({red, yellow, green});

`ifdef PED_AUDIO_EN
    logic [CNT_W-1:0] chirp_cnt;
`else
    assign chirp = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            req_pend  <= 1'b0;
            countdown <= '0;
            fault     <= 1'b0;
            red_q     <= 1'b0;
            timer     <= '0;
            flash_cnt <= '0;
`ifdef PED_AUDIO_EN
            chirp     <= 1'b0;
            chirp_cnt <= '0;
`endif
        end else begin
            red_q <= red;
            if (press && state != ST_WALK && state != ST_FAULT)
                req_pend <= 1'b1;
`ifdef PED_AUDIO_EN
            chirp     <= 1'b0;
            chirp_cnt <= '0;
`endif
            // A bad vehicle lamp pattern overrides every other transition
            if (!onehot) begin
                state     <= ST_FAULT;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                countdown <= '0;
                fault     <= 1'b1;
            end else begin
                fault <= 1'b0;
                unique case (state)
                    ST_IDLE: begin
                        if (req_pend || press)
                            state <= ST_WAIT_RED;
                    end
                    ST_WAIT_RED: begin
                        if (red_rise) begin
                            state     <= ST_WALK;
                            walk      <= 1'b1;
                            dont_walk <= 1'b0;
                            timer     <= CNT_W'(WALK_CYC - 1);
                            req_pend  <= 1'b0;
                        end
                    end
                    ST_WALK: begin
                        if (!red) begin
                            state     <= ST_IDLE;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                        end else if (timer == '0) begin
                            state     <= ST_CLEAR;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            countdown <= CNT_W'(CLEAR_CYC);
                            flash_cnt <= '0;
                        end else begin
                            timer <= timer - 1'b1;
`ifdef PED_AUDIO_EN
                            if (chirp_cnt == CNT_W'(CHIRP_DIV - 1)) begin
                                chirp <= ~chirp;
                            end else begin
                                chirp     <= chirp;
                                chirp_cnt <= chirp_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    ST_CLEAR: begin
                        if (!red) begin
                            state     <= ST_IDLE;
                            dont_walk <= 1'b1;
                            countdown <= '0;
                        end else if (countdown <= CNT_W'(1)) begin
                            state     <= ST_HOLD;
                            dont_walk <= 1'b1;
                            countdown <= '0;
                        end else begin
                            countdown <= countdown - 1'b1;
                            if (flash_cnt == CNT_W'(FLASH_DIV - 1)) begin
                                flash_cnt <= '0;
                                dont_walk <= ~dont_walk;
                            end else begin
                                flash_cnt <= flash_cnt + 1'b1;
                            end
`ifdef PED_AUDIO_EN
                            if (chirp_cnt == CNT_W'(2 * CHIRP_DIV - 1)) begin
                                chirp <= ~chirp;
                            end else begin
                                chirp     <= chirp;
                                chirp_cnt <= chirp_cnt + 1'b1;
                            end
`endif
                        end
                    end
                    ST_HOLD: begin
                        if (!red)
                            state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed scenarios plus random traffic,
// compared each cycle against an elapsed-time reference model.
module tb_ped_crossing_ctrl;

    localparam int WALK_CYC  = 20;
    localparam int CLEAR_CYC = 10;
    localparam int FLASH_DIV = 2;
    localparam int CHIRP_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       red = 1'b0;
    logic       yellow = 1'b0;
    logic       green = 1'b1;
    logic       ped_btn = 1'b0;
    logic       walk;
    logic       dont_walk;
    logic       req_pend;
    logic [7:0] countdown;
    logic       fault;
    logic       chirp;

    ped_crossing_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .red       (red),
        .yellow    (yellow),
        .green     (green),
        .ped_btn   (ped_btn),
        .walk      (walk),
        .dont_walk (dont_walk),
        .req_pend  (req_pend),
        .countdown (countdown),
        .fault     (fault),
        .chirp     (chirp)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_WAIT, M_WALK, M_CLEAR, M_HOLD, M_FAULT} mph_t;

    mph_t ph = M_IDLE;
    int   k = 0;
    bit   pend = 0;
    bit   red_prev = 0;
    bit   b1 = 0, b2 = 0, b3 = 0;
    int   checks = 0;
    int   errors = 0;
    int   tcnt = 50;
    int   ovr = 0;
    int   wl = 0;
    int   last_wl = 0;
    bit   walk_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t",
                   tag, got, exp, $time);
        end
    endtask

    task automatic apply_inputs();
        case (ovr)
            1: {red, yellow, green} = 3'b001;
            2: {red, yellow, green} = 3'b110;
            default: begin
                red    = (tcnt < 40);
                green  = (tcnt >= 40 && tcnt < 70);
                yellow = (tcnt >= 70);
            end
        endcase
    endtask

    task automatic model_edge();
        bit press, oh, rr, pset, served;
        press  = b2 && !b3;
        served = 0;
        if (!reset) begin
            ph = M_IDLE; k = 0; pend = 0; red_prev = 0;
            b1 = 0; b2 = 0; b3 = 0;
            return;
        end
        oh   = (int'(red) + int'(yellow) + int'(green)) == 1;
        rr   = red && !red_prev;
        pset = press && ph != M_WALK && ph != M_FAULT;
        if (!oh) begin
            ph = M_FAULT;
            k  = 0;
        end else begin
            case (ph)
                M_IDLE: if (pend || press) ph = M_WAIT;
                M_WAIT: if (rr) begin ph = M_WALK; k = 0; served = 1; end
                M_WALK: begin
                    if (!red) ph = M_IDLE;
                    else if (k == WALK_CYC - 1) begin ph = M_CLEAR; k = 0; end
                    else k++;
                end
                M_CLEAR: begin
                    if (!red) ph = M_IDLE;
                    else if (k == CLEAR_CYC - 1) ph = M_HOLD;
                    else k++;
                end
                M_HOLD: if (!red) ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
        end
        pend     = served ? 1'b0 : (pend | pset);
        red_prev = red;
        b3 = b2; b2 = b1; b1 = ped_btn;
    endtask

    task automatic check_outs();
        bit ew, edw, efl, ech;
        int ecd;
        ew = 0; edw = 1; efl = 0; ech = 0; ecd = 0;
        case (ph)
            M_WALK: begin
                ew = 1; edw = 0;
`ifdef PED_AUDIO_EN
                ech = ((k / CHIRP_DIV) % 2) == 1;
`endif
            end
            M_CLEAR: begin
                edw = ((k / FLASH_DIV) % 2) == 0;
                ecd = CLEAR_CYC - k;
`ifdef PED_AUDIO_EN
                ech = ((k / (2 * CHIRP_DIV)) % 2) == 1;
`endif
            end
            M_FAULT: efl = 1;
            default: ;
        endcase
        chk("walk", 32'(walk), 32'(ew));
        chk("dont_walk", 32'(dont_walk), 32'(edw));
        chk("req_pend", 32'(req_pend), 32'(pend));
        chk("countdown", 32'(countdown), 32'(ecd));
        chk("fault", 32'(fault), 32'(efl));
        chk("chirp", 32'(chirp), 32'(ech));
    endtask

    task automatic step();
        apply_inputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs();
        if (walk === 1'b1) begin
            wl++;
            walk_seen = 1;
        end else begin
            if (wl > 0) last_wl = wl;
            wl = 0;
        end
        tcnt = (tcnt + 1) % 80;
    endtask

    task automatic goto_t(input int t);
        while (tcnt != t) step();
    endtask

    task automatic push_btn();
        ped_btn = 1'b1;
        repeat (3) step();
        ped_btn = 1'b0;
    endtask

    task automatic wait_walk(input string tag, input int bound);
        int n;
        n = 0;
        while (walk !== 1'b1 && n < bound) begin
            step();
            n++;
        end
        chk(tag, 32'(walk), 32'd1);
    endtask

    initial begin
        int r;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step();
        chk("rst_dont_walk", 32'(dont_walk), 32'd1);
        chk("rst_countdown", 32'(countdown), 32'd0);
        reset = 1'b1;

        // press in green, served at next red rise
        step();
        push_btn();
        chk("pend_after_press", 32'(req_pend), 32'd1);
        wait_walk("walk_after_green_press", 100);
        repeat (40) step();
        chk("walk_len", 32'(last_wl), 32'(WALK_CYC));

        // press mid-red: no service until next red
        goto_t(10);
        walk_seen = 0;
        push_btn();
        goto_t(40);
        chk("no_walk_same_red", 32'(walk_seen), 32'd0);
        chk("pend_kept", 32'(req_pend), 32'd1);
        wait_walk("walk_next_red", 100);
        push_btn();
        repeat (3) step();
        chk("press_in_walk", 32'(req_pend), 32'd0);
        goto_t(45);

        // red dropped during WALK aborts
        push_btn();
        wait_walk("walk_before_abort", 100);
        repeat (4) step();
        ovr = 1;
        step();
        ovr = 0;
        chk("abort_walk", 32'(walk), 32'd0);
        chk("abort_dont_walk", 32'(dont_walk), 32'd1);
        chk("abort_countdown", 32'(countdown), 32'd0);
        repeat (3) step();

        // non-one-hot lamps with a pending request
        goto_t(45);
        push_btn();
        repeat (3) step();
        chk("pend_before_fault", 32'(req_pend), 32'd1);
        ovr = 2;
        repeat (4) step();
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_dont_walk", 32'(dont_walk), 32'd1);
        ovr = 0;
        step();
        chk("fault_clear", 32'(fault), 32'd0);
        chk("fault_pend_kept", 32'(req_pend), 32'd1);

        // reset during CLEAR drops a request made in CLEAR
        wait_walk("walk_before_reset", 100);
        repeat (WALK_CYC) step();
        push_btn();
        step();
        chk("pend_in_clear", 32'(req_pend), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("reset_pend", 32'(req_pend), 32'd0);
        chk("reset_walk", 32'(walk), 32'd0);
        chk("reset_cd", 32'(countdown), 32'd0);

        // random traffic disturbances and button activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) ped_btn = ~ped_btn;
            r = int'($urandom_range(0, 199));
            ovr = (r < 3) ? 1 : (r < 5) ? 2 : 0;
            reset = ($urandom_range(0, 499) != 0);
            step();
        end
        ovr = 0;
        reset = 1'b1;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
